fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_if.sv | 25 ++
 rtl/fifo_rd_stream.sv | 93 +++++++++
 tb/tb_fifo_rd_stream.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port plus output stream bundle; m_parity present only with FIFO_RD_STREAM_PARITY_EN
interface fifo_rd_stream_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rd_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
`ifdef FIFO_RD_STREAM_PARITY_EN
   logic                  m_parity;

   modport master (input fifo_empty, data_out, m_ready,
                   output rd_en, m_valid, m_data, m_last, m_parity);
   modport slave  (output fifo_empty, data_out, m_ready,
                   input rd_en, m_valid, m_data, m_last, m_parity);
`else
   modport master (input fifo_empty, data_out, m_ready,
                   output rd_en, m_valid, m_data, m_last);
   modport slave  (output fifo_empty, data_out, m_ready,
                   input rd_en, m_valid, m_data, m_last);
`endif
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - pops a 1-cycle-latency FIFO into a packetised valid/ready stream via a 2-entry buffer
// Optional even-parity output per word with FIFO_RD_STREAM_PARITY_EN.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int PKT_LEN    = 4
) (
   input  logic             rd_clk,
   input  logic             rd_rst,
   fifo_rd_stream_if.master bus
);
   localparam int CW = $clog2(PKT_LEN) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(PKT_LEN - 1);

`ifdef FIFO_RD_STREAM_PARITY_EN
   localparam int EW = DATA_WIDTH + 2;
`else
   localparam int EW = DATA_WIDTH + 1;
`endif

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   logic [1:0]    state;
   logic          pend;
   logic [CW-1:0] wcnt;
   logic [EW-1:0] e0;
   logic [EW-1:0] e1;
   logic [EW-1:0] e_new;
   logic          hs;
   logic          wr;
   logic          wr_last;
   logic [1:0]    occ;

   // pend marks a pop issued last cycle whose word is on data_out now
   assign wr      = pend;
   assign wr_last = (wcnt == LAST_CNT);
   assign hs      = (state != EMPTY) & bus.m_ready;
   assign occ     = state + {1'b0, pend};
   assign bus.rd_en = !rd_rst & !bus.fifo_empty & ((occ < 2'd2) | hs);

`ifdef FIFO_RD_STREAM_PARITY_EN
   assign e_new        = {^bus.data_out, wr_last, bus.data_out};
   assign bus.m_parity = e0[DATA_WIDTH+1];
`else
   assign e_new = {wr_last, bus.data_out};
`endif

   assign bus.m_valid = (state != EMPTY);
   assign bus.m_data  = e0[DATA_WIDTH-1:0];
   assign bus.m_last  = e0[DATA_WIDTH];

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state <= EMPTY;
         pend  <= 1'b0;
         wcnt  <= '0;
         e0    <= '0;
         e1    <= '0;
      end else begin
         pend <= bus.rd_en;
         if (wr) begin
            wcnt <= wr_last ? '0 : wcnt + 1'b1;
         end
         // e0 is always the oldest entry; e1 only ever holds the younger one in TWO
         case (state)
            EMPTY: begin
               if (wr) begin
                  e0    <= e_new;
                  state <= ONE;
               end
            end
            ONE: begin
               if (wr && hs) begin
                  e0 <= e_new;
               end else if (wr) begin
                  e1    <= e_new;
                  state <= TWO;
               end else if (hs) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (hs) begin
                  e0    <= e1;
                  state <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed self-checking bench for fifo_rd_stream (PKT_LEN=4 and PKT_LEN=1 instances)
module tb_fifo_rd_stream;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_rd_stream_if #(.DATA_WIDTH(8)) bus_a ();
   fifo_rd_stream_if #(.DATA_WIDTH(8)) bus_b ();

   fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(4)) dut_a (.rd_clk(clk), .rd_rst(rst), .bus(bus_a));
   fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(1)) dut_b (.rd_clk(clk), .rd_rst(rst), .bus(bus_b));

   // FIFO models: word appears on data_out one cycle after rd_en
   logic [7:0] mem_a [0:63];
   logic [7:0] mem_b [0:63];
   int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
   assign bus_a.fifo_empty = (wp_a == rp_a);
   assign bus_b.fifo_empty = (wp_b == rp_b);

   always @(posedge clk) begin
      if (bus_a.rd_en) begin
         bus_a.data_out <= mem_a[rp_a[5:0]];
         rp_a <= rp_a + 1;
      end
      if (bus_b.rd_en) begin
         bus_b.data_out <= mem_b[rp_b[5:0]];
         rp_b <= rp_b + 1;
      end
   end

   task automatic push_a(input logic [7:0] d);
      mem_a[wp_a[5:0]] = d;
      wp_a = wp_a + 1;
   endtask

   task automatic push_b(input logic [7:0] d);
      mem_b[wp_b[5:0]] = d;
      wp_b = wp_b + 1;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus_a.m_ready = 1'b0;
      bus_b.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push_a(8'(i + 1));
      repeat (3) step();
      n_checks++; if (bus_a.rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus_a.rd_en); end
      n_checks++; if (bus_a.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", bus_a.m_valid); end
      n_checks++; if (bus_a.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", bus_a.m_data); end
      n_checks++; if (bus_a.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b want 0", bus_a.m_last); end
      n_checks++; if (bus_b.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_m_valid: got %b want 0", bus_b.m_valid); end
   endtask

   task automatic test_streaming();
      bus_a.m_ready = 1'b1;
      rst = 1'b0;
      #1;
      n_checks++; if (bus_a.rd_en !== 1'b1) begin n_fail++; $display("FAIL stream_first_rd_en: got %b want 1", bus_a.rd_en); end
      step();
      n_checks++; if (bus_a.m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency_n1: got %b want 0", bus_a.m_valid); end
      step();
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (bus_a.m_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus_a.m_valid); end
         n_checks++; if (bus_a.m_data !== 8'(i + 1)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, bus_a.m_data, 8'(i + 1)); end
         n_checks++; if (bus_a.m_last !== ((i == 3) || (i == 7))) begin n_fail++; $display("FAIL stream_last[%0d]: got %b want %b", i, bus_a.m_last, (i == 3) || (i == 7)); end
         step();
      end
      n_checks++; if (bus_a.m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b want 0", bus_a.m_valid); end
   endtask

   task automatic test_backpressure();
      int pops;
      logic [8:0] got [$];
      pops = 0;
      bus_a.m_ready = 1'b0;
      push_a(8'h01); push_a(8'h02); push_a(8'h03);
      #1;
      for (int k = 0; k < 6; k++) begin
         if (bus_a.rd_en === 1'b1) pops++;
         if (k >= 2) begin
            n_checks++; if (bus_a.m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, bus_a.m_valid); end
            n_checks++; if (bus_a.m_data !== 8'h01) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h want 01", k, bus_a.m_data); end
         end
         step();
      end
      n_checks++; if (pops != 2) begin n_fail++; $display("FAIL bp_pop_count: got %0d want 2", pops); end
      bus_a.m_ready = 1'b1;
      #1;
      for (int c = 0; c < 20 && got.size() < 3; c++) begin
         if (bus_a.m_valid === 1'b1) got.push_back({bus_a.m_last, bus_a.m_data});
         step();
      end
      n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_word_count: got %0d want 3", got.size()); end
      for (int i = 0; i < got.size() && i < 3; i++) begin
         n_checks++; if (got[i] !== {1'b0, 8'(i + 1)}) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], {1'b0, 8'(i + 1)}); end
      end
      step();
      n_checks++; if (bus_a.m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra: got %b want 0", bus_a.m_valid); end
   endtask

   task automatic test_empty_edge();
      int n_rd, n_v, rd_k, v_k;
      n_rd = 0; n_v = 0; rd_k = -1; v_k = -1;
      bus_a.m_ready = 1'b1;
      push_a(8'hA5);
      #1;
      for (int k = 0; k < 6; k++) begin
         if (bus_a.rd_en === 1'b1) begin n_rd++; rd_k = k; end
         if (bus_a.m_valid === 1'b1) begin
            n_v++; v_k = k;
            n_checks++; if (bus_a.m_data !== 8'hA5) begin n_fail++; $display("FAIL edge_data: got %h want a5", bus_a.m_data); end
            n_checks++; if (bus_a.m_last !== 1'b1) begin n_fail++; $display("FAIL edge_last: got %b want 1", bus_a.m_last); end
         end
         step();
      end
      n_checks++; if (n_rd != 1) begin n_fail++; $display("FAIL edge_rd_pulses: got %0d want 1", n_rd); end
      n_checks++; if (n_v != 1) begin n_fail++; $display("FAIL edge_valid_cycles: got %0d want 1", n_v); end
      n_checks++; if (v_k != rd_k + 2) begin n_fail++; $display("FAIL edge_latency: got %0d want %0d", v_k - rd_k, 2); end
   endtask

   task automatic test_reset_mid();
      logic [8:0] got [$];
      bus_a.m_ready = 1'b0;
      push_a(8'hB1); push_a(8'hB2); push_a(8'hB3);
      #1;
      repeat (4) step();
      n_checks++; if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== 8'hB1) begin n_fail++; $display("FAIL rmid_pre: got v=%b d=%h want v=1 d=b1", bus_a.m_valid, bus_a.m_data); end
      rst = 1'b1;
      #1;
      n_checks++; if (bus_a.m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", bus_a.m_valid); end
      n_checks++; if (bus_a.m_data !== 8'h00 || bus_a.m_last !== 1'b0) begin n_fail++; $display("FAIL rmid_data: got d=%h l=%b want d=00 l=0", bus_a.m_data, bus_a.m_last); end
      n_checks++; if (bus_a.rd_en !== 1'b0) begin n_fail++; $display("FAIL rmid_rd_en: got %b want 0", bus_a.rd_en); end
      wp_a = rp_a;
      step(); step();
      push_a(8'hC1); push_a(8'hC2); push_a(8'hC3); push_a(8'hC4);
      bus_a.m_ready = 1'b1;
      rst = 1'b0;
      #1;
      for (int c = 0; c < 20 && got.size() < 4; c++) begin
         if (bus_a.m_valid === 1'b1) got.push_back({bus_a.m_last, bus_a.m_data});
         step();
      end
      n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL rmid_word_count: got %0d want 4", got.size()); end
      for (int i = 0; i < got.size() && i < 4; i++) begin
         n_checks++; if (got[i] !== {(i == 3) ? 1'b1 : 1'b0, 8'hC1 + 8'(i)}) begin n_fail++; $display("FAIL rmid_word[%0d]: got %h want %h", i, got[i], {(i == 3) ? 1'b1 : 1'b0, 8'hC1 + 8'(i)}); end
      end
   endtask

`ifdef FIFO_RD_STREAM_PARITY_EN
   task automatic test_parity();
      logic [7:0] vals [4];
      logic       par  [4];
      int idx;
      vals = '{8'h00, 8'h01, 8'hFF, 8'h07};
      par  = '{1'b0, 1'b1, 1'b0, 1'b1};
      idx = 0;
      bus_a.m_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_a(vals[i]);
      #1;
      for (int c = 0; c < 20 && idx < 4; c++) begin
         if (bus_a.m_valid === 1'b1) begin
            n_checks++; if (bus_a.m_data !== vals[idx] || bus_a.m_parity !== par[idx]) begin n_fail++; $display("FAIL parity[%0d]: got d=%h p=%b want d=%h p=%b", idx, bus_a.m_data, bus_a.m_parity, vals[idx], par[idx]); end
            idx++;
         end
         step();
      end
      n_checks++; if (idx != 4) begin n_fail++; $display("FAIL parity_count: got %0d want 4", idx); end
   endtask
`endif

   task automatic test_back_to_back();
      logic [7:0] exp [20];
      int idx;
      logic prev_stall;
      logic [7:0] prev_data;
      idx = 0;
      prev_stall = 1'b0;
      prev_data = 8'h00;
      for (int i = 0; i < 20; i++) begin
         exp[i] = 8'(i * 37 + 5);
         push_b(exp[i]);
      end
      for (int c = 0; c < 300 && idx < 20; c++) begin
         @(negedge clk);
         bus_b.m_ready = 1'($urandom_range(0, 1));
         #1;
         if (prev_stall) begin
            n_checks++; if (bus_b.m_valid !== 1'b1 || bus_b.m_data !== prev_data) begin n_fail++; $display("FAIL b2b_hold: got v=%b d=%h want v=1 d=%h", bus_b.m_valid, bus_b.m_data, prev_data); end
         end
         if (bus_b.m_valid === 1'b1) begin
            if (bus_b.m_ready === 1'b1) begin
               n_checks++; if (bus_b.m_data !== exp[idx]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", idx, bus_b.m_data, exp[idx]); end
               n_checks++; if (bus_b.m_last !== 1'b1) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b want 1", idx, bus_b.m_last); end
               idx++;
            end
            prev_stall = !bus_b.m_ready;
            prev_data  = bus_b.m_data;
         end else begin
            prev_stall = 1'b0;
         end
      end
      n_checks++; if (idx != 20) begin n_fail++; $display("FAIL b2b_count: got %0d want 20", idx); end
      bus_b.m_ready = 1'b1;
      repeat (3) step();
      n_checks++; if (bus_b.m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: got %b want 0", bus_b.m_valid); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_empty_edge();
      test_reset_mid();
`ifdef FIFO_RD_STREAM_PARITY_EN
      test_parity();
`endif
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
